tdc_evfifo: RTL and testbench

Timestamp event buffer that sits directly downstream of the TDC channel cores. It captures per-channel detect pulses with polarity and timestamp, merges all channels into one FIFO, and exposes the queued events to the LM32 through a Wishbone slave with a level/overflow interrupt. It occupies a Wishbone slot on the conbus beside the TDC host interface and shares its clock and reset.

---
 rtl/tdc_evfifo_pkg.sv | 31 +++
 rtl/tdc_evfifo_ram.sv | 27 ++
 rtl/tdc_evfifo.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_tdc_evfifo.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_evfifo_pkg.sv
// Shared constants for the TDC event FIFO: register map, bit positions, entry sizing.
package tdc_evfifo_pkg;

    localparam logic [3:0] ADDR_STATUS  = 4'd0;
    localparam logic [3:0] ADDR_CTRL    = 4'd1;
    localparam logic [3:0] ADDR_THRESH  = 4'd2;
    localparam logic [3:0] ADDR_DATA_LO = 4'd3;
    localparam logic [3:0] ADDR_DATA_HI = 4'd4;
    localparam logic [3:0] ADDR_DROPS   = 4'd5;

    localparam int STAT_EMPTY = 16;
    localparam int STAT_FULL  = 17;
    localparam int STAT_OVF   = 18;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLEAR  = 2;

    localparam int DHI_VALID  = 31;
    localparam int DHI_POL    = 30;
    localparam int DHI_CH_LSB = 24;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int entry_width(input int n, input int ts);
        return ch_width(n) + 1 + ts;
    endfunction

endpackage

// File: rtl/tdc_evfifo_ram.sv
// Event storage: simple dual-port RAM, one write port and one registered read port.
// Latency: read data valid 1 cycle after rd_en. Backpressure: none, caller tracks occupancy.
module tdc_evfifo_ram #(
    parameter int g_DEPTH_LOG2 = 9,
    parameter int g_WIDTH      = 40
) (
    input  logic                    sys_clk,
    input  logic                    wr_en,
    input  logic [g_DEPTH_LOG2-1:0] wr_addr,
    input  logic [g_WIDTH-1:0]      wr_dat,
    input  logic                    rd_en,
    input  logic [g_DEPTH_LOG2-1:0] rd_addr,
    output logic [g_WIDTH-1:0]      rd_dat
);

    logic [g_WIDTH-1:0] mem [1 << g_DEPTH_LOG2];

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/tdc_evfifo.sv
// TDC event FIFO: merges per-channel detects into one queue read over Wishbone; TDC_EVFIFO_DROPCNT_EN adds DROPS.
// Latency: detect to level 2 cycles, Wishbone ack 2 cycles after stb.
// Backpressure: none upstream; events hitting a busy holding register or a full FIFO are dropped and flag OVF.
module tdc_evfifo
    import tdc_evfifo_pkg::*;
#(
    parameter int g_CHANNEL_COUNT = 2,
    parameter int g_TS_WIDTH      = 38,
    parameter int g_DEPTH_LOG2    = 9
) (
    input  logic                                  wb_clk_i,
    input  logic                                  rst_n_i,
    input  logic [g_CHANNEL_COUNT-1:0]            detect_i,
    input  logic [g_CHANNEL_COUNT-1:0]            polarity_i,
    input  logic [g_CHANNEL_COUNT*g_TS_WIDTH-1:0] ts_i,
    input  logic [3:0]                            wb_addr_i,
    input  logic [31:0]                           wb_data_i,
    output logic [31:0]                           wb_data_o,
    input  logic                                  wb_cyc_i,
    input  logic                                  wb_stb_i,
    input  logic                                  wb_we_i,
    input  logic [3:0]                            wb_sel_i,
    output logic                                  wb_ack_o,
    output logic                                  wb_irq_o
);

    localparam int CHW   = ch_width(g_CHANNEL_COUNT);
    localparam int EW    = entry_width(g_CHANNEL_COUNT, g_TS_WIDTH);
    localparam int DEPTH = 1 << g_DEPTH_LOG2;
    localparam int LW    = g_DEPTH_LOG2 + 1;

    logic unused_in;
    assign unused_in = ^{wb_sel_i, wb_data_i[31:16]};

    // Wishbone request stage
    logic        req_q;
    logic        we_q;
    logic [3:0]  addr_q;
    logic [15:0] wdat_q;
    logic        wb_start;
    logic        wr_ctrl;
    logic        wr_thresh;
    logic        flush;
    logic        pop;

    logic        ctrl_en;
    logic        ctrl_irq_en;
    logic [15:0] thresh;
    logic        ovf;

    logic [g_CHANNEL_COUNT-1:0] hold_vld;
    logic [g_CHANNEL_COUNT-1:0] hold_pol;
    logic [g_TS_WIDTH-1:0]      hold_ts [g_CHANNEL_COUNT];

    logic                       arb_vld;
    logic [CHW-1:0]             arb_sel;
    logic                       sel_pol;
    logic [g_TS_WIDTH-1:0]      sel_ts;
    logic [g_CHANNEL_COUNT-1:0] arb_free;
    logic [g_CHANNEL_COUNT-1:0] hold_drop;
    logic                       fifo_drop;
    logic                       any_drop;

    logic [g_DEPTH_LOG2-1:0] wr_ptr;
    logic [g_DEPTH_LOG2-1:0] rd_ptr;
    logic [LW-1:0]           level;
    logic [LW-1:0]           ram_cnt;
    logic                    full;
    logic                    push;
    logic                    rd_issue;
    logic                    inflight;
    logic                    head_vld;
    logic [EW-1:0]           head_dat;
    logic [EW-1:0]           ram_rd_dat;

    logic [31:0] rd_mux;
    logic [31:0] drops_rd;

    assign wb_start  = wb_cyc_i & wb_stb_i & ~req_q & ~wb_ack_o;
    assign wr_ctrl   = req_q & we_q & (addr_q == ADDR_CTRL);
    assign wr_thresh = req_q & we_q & (addr_q == ADDR_THRESH);
    assign flush     = wr_ctrl & wdat_q[CTRL_CLEAR];
    assign pop       = req_q & ~we_q & (addr_q == ADDR_DATA_HI) & head_vld;

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n_i) begin
            req_q  <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            wdat_q <= '0;
        end else begin
            req_q <= wb_start;
            if (wb_start) begin
                we_q   <= wb_we_i;
                addr_q <= wb_addr_i;
                wdat_q <= wb_data_i[15:0];
            end
        end
    end

    // Lowest-indexed occupied holding register wins
    always_comb begin
        arb_vld = 1'b0;
        arb_sel = '0;
        sel_pol = 1'b0;
        sel_ts  = '0;
        for (int i = g_CHANNEL_COUNT - 1; i >= 0; i--) begin
            if (hold_vld[i]) begin
                arb_vld = 1'b1;
                arb_sel = CHW'(i);
                sel_pol = hold_pol[i];
                sel_ts  = hold_ts[i];
            end
        end
    end

    always_comb begin
        arb_free  = '0;
        hold_drop = '0;
        for (int i = 0; i < g_CHANNEL_COUNT; i++) begin
            arb_free[i]  = arb_vld && (arb_sel == CHW'(i));
            hold_drop[i] = ctrl_en && detect_i[i] && hold_vld[i] && !arb_free[i];
        end
    end

    assign full      = (level == LW'(DEPTH));
    assign push      = arb_vld & ~full;
    assign fifo_drop = arb_vld & full;
    assign any_drop  = fifo_drop | (|hold_drop);

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n_i || flush) begin
            hold_vld <= '0;
        end else begin
            for (int n = 0; n < g_CHANNEL_COUNT; n++) begin
                if (ctrl_en && detect_i[n] && (!hold_vld[n] || arb_free[n])) begin
                    hold_vld[n] <= 1'b1;
                end else if (arb_free[n]) begin
                    hold_vld[n] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        for (int n = 0; n < g_CHANNEL_COUNT; n++) begin
            if (ctrl_en && detect_i[n] && (!hold_vld[n] || arb_free[n])) begin
                hold_pol[n] <= polarity_i[n];
                hold_ts[n]  <= ts_i[n*g_TS_WIDTH +: g_TS_WIDTH];
            end
        end
    end

    // Prefetch into head when it is empty or being popped; at most one read in flight
    assign rd_issue = (ram_cnt != '0) & ~inflight & (~head_vld | pop);

    tdc_evfifo_ram #(
        .g_DEPTH_LOG2 (g_DEPTH_LOG2),
        .g_WIDTH      (EW)
    ) u_ram (
        .sys_clk (wb_clk_i),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_dat  ({arb_sel, sel_pol, sel_ts}),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr),
        .rd_dat  (ram_rd_dat)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n_i || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            head_vld <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            inflight <= rd_issue;
            ram_cnt  <= ram_cnt + LW'(push) - LW'(rd_issue);
            level    <= level + LW'(push) - LW'(pop);
            if (inflight) begin
                head_vld <= 1'b1;
            end else if (pop) begin
                head_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (inflight) begin
            head_dat <= ram_rd_dat;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n_i) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            thresh      <= 16'd1;
            ovf         <= 1'b0;
            wb_irq_o    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en     <= wdat_q[CTRL_ENABLE];
                ctrl_irq_en <= wdat_q[CTRL_IRQ_EN];
            end
            if (wr_thresh) begin
                thresh <= wdat_q;
            end
            if (flush) begin
                ovf <= 1'b0;
            end else if (any_drop) begin
                ovf <= 1'b1;
            end
            wb_irq_o <= ctrl_irq_en &
                        (((16'(level) >= thresh) && (thresh != 16'd0)) || ovf);
        end
    end

`ifdef TDC_EVFIFO_DROPCNT_EN
    logic [31:0] drop_cnt;
    logic [7:0]  drop_inc;
    logic [32:0] drop_sum;

    always_comb begin
        drop_inc = 8'(fifo_drop);
        for (int i = 0; i < g_CHANNEL_COUNT; i++) begin
            drop_inc = drop_inc + 8'(hold_drop[i]);
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + 33'(drop_inc);

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n_i || flush) begin
            drop_cnt <= '0;
        end else if (drop_sum[32]) begin
            drop_cnt <= '1;
        end else begin
            drop_cnt <= drop_sum[31:0];
        end
    end

    assign drops_rd = drop_cnt;
`else
    assign drops_rd = '0;
`endif

    logic [g_TS_WIDTH-1:0] head_ts;
    logic                  head_pol;
    logic [CHW-1:0]        head_ch;
    logic [55:0]           head_ts_ext;

    assign head_ts     = head_dat[g_TS_WIDTH-1:0];
    assign head_pol    = head_dat[g_TS_WIDTH];
    assign head_ch     = head_dat[EW-1 -: CHW];
    assign head_ts_ext = 56'(head_ts);

    always_comb begin
        rd_mux = '0;
        case (addr_q)
            ADDR_STATUS: begin
                rd_mux[15:0]       = 16'(level);
                rd_mux[STAT_EMPTY] = (level == '0);
                rd_mux[STAT_FULL]  = full;
                rd_mux[STAT_OVF]   = ovf;
            end
            ADDR_CTRL: begin
                rd_mux[CTRL_ENABLE] = ctrl_en;
                rd_mux[CTRL_IRQ_EN] = ctrl_irq_en;
            end
            ADDR_THRESH:  rd_mux[15:0] = thresh;
            ADDR_DATA_LO: rd_mux = head_vld ? head_ts_ext[31:0] : 32'd0;
            ADDR_DATA_HI: begin
                if (head_vld) begin
                    rd_mux[DHI_VALID]        = 1'b1;
                    rd_mux[DHI_POL]          = head_pol;
                    rd_mux[DHI_CH_LSB +: 6]  = 6'(head_ch);
                    rd_mux[23:0]             = head_ts_ext[55:32];
                end
            end
            ADDR_DROPS:   rd_mux = drops_rd;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n_i) begin
            wb_ack_o  <= 1'b0;
            wb_data_o <= '0;
        end else begin
            wb_ack_o  <= req_q;
            wb_data_o <= (req_q && !we_q) ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_tdc_evfifo.sv
// Directed bench for tdc_evfifo: 2 channels, 38-bit timestamps, 512-entry FIFO.
module tb_tdc_evfifo;

`ifdef TDC_EVFIFO_DROPCNT_EN
    localparam bit DROPCNT = 1'b1;
`else
    localparam bit DROPCNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  detect;
    logic [1:0]  polarity;
    logic [75:0] ts;
    logic [3:0]  wb_addr;
    logic [31:0] wb_wdat;
    logic [31:0] wb_rdat;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_ack;
    logic        wb_irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tdc_evfifo #(
        .g_CHANNEL_COUNT (2),
        .g_TS_WIDTH      (38),
        .g_DEPTH_LOG2    (9)
    ) dut (
        .wb_clk_i   (clk),
        .rst_n_i    (rst_n),
        .detect_i   (detect),
        .polarity_i (polarity),
        .ts_i       (ts),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_wdat),
        .wb_data_o  (wb_rdat),
        .wb_cyc_i   (wb_cyc),
        .wb_stb_i   (wb_stb),
        .wb_we_i    (wb_we),
        .wb_sel_i   (wb_sel),
        .wb_ack_o   (wb_ack),
        .wb_irq_o   (wb_irq)
    );

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wb_access(input logic [3:0] a, input logic we, input logic [31:0] wd,
                             output logic [31:0] rd);
        bit got = 1'b0;
        rd      = 32'hXXXX_XXXX;
        wb_addr = a;
        wb_we   = we;
        wb_wdat = wd;
        wb_cyc  = 1'b1;
        wb_stb  = 1'b1;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            if (wb_ack) begin
                got = 1'b1;
                rd  = wb_rdat;
            end
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL wb_timeout: addr %0d no ack within 16 cycles", a);
        end
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [31:0] rd);
        wb_access(a, 1'b0, 32'd0, rd);
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] wd);
        logic [31:0] dummy;
        wb_access(a, 1'b1, wd, dummy);
    endtask

    task automatic pulse(input logic [1:0] mask, input logic [1:0] pol,
                         input logic [37:0] t0, input logic [37:0] t1);
        detect   = mask;
        polarity = pol;
        ts       = {t1, t0};
        @(negedge clk);
        detect = 2'b00;
    endtask

    task automatic burst(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            detect   = 2'b01;
            polarity = 2'b00;
            ts       = {38'd0, 38'(base + i)};
            @(negedge clk);
        end
        detect = 2'b00;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        idle(3);
        checks++;
        if (wb_ack !== 1'b0 || wb_rdat !== 32'd0 || wb_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b data=%h irq=%b, want 0/0/0", wb_ack, wb_rdat, wb_irq);
        end
        rst_n = 1'b1;
        idle(1);
        wb_read(4'd0, d);
        checks++;
        if (d !== 32'h0001_0000) begin errors++; $display("FAIL reset_status: got %h want 00010000", d); end
        wb_read(4'd1, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", d); end
        wb_read(4'd2, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL reset_thresh: got %h want 1", d); end
        wb_read(4'd7, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL unmapped_read: got %h want 0", d); end
    endtask

    task automatic test_single();
        logic [31:0] d;
        wb_write(4'd1, 32'h1);
        pulse(2'b10, 2'b10, 38'd0, 38'h2A_DEADBEEF);
        idle(4);
        wb_read(4'd0, d);
        checks++;
        if (d !== 32'h0000_0001) begin errors++; $display("FAIL single_level: got %h want 00000001", d); end
        wb_read(4'd3, d);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_lo: got %h want deadbeef", d); end
        wb_read(4'd4, d);
        checks++;
        if (d !== 32'hC100_002A) begin errors++; $display("FAIL single_hi: got %h want c100002a", d); end
        wb_read(4'd4, d);
        checks++;
        if (d[31] !== 1'b0) begin errors++; $display("FAIL single_hi_empty: got %h want valid=0", d); end
        wb_read(4'd3, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL single_lo_empty: got %h want 0", d); end
        wb_read(4'd0, d);
        checks++;
        if (d !== 32'h0001_0000) begin errors++; $display("FAIL single_after: got %h want 00010000", d); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        logic [31:0] exp [5] = '{32'h0000_0002, 32'd5, 32'h8000_0000, 32'd6, 32'h8100_0000};
        logic [3:0]  adr [5] = '{4'd0, 4'd3, 4'd4, 4'd3, 4'd4};
        pulse(2'b11, 2'b00, 38'd5, 38'd6);
        idle(4);
        for (int i = 0; i < 5; i++) begin
            wb_read(adr[i], d);
            checks++;
            if (d !== exp[i]) begin errors++; $display("FAIL simul_%0d: got %h want %h", i, d, exp[i]); end
        end
        wb_read(4'd0, d);
        checks++;
        if (d !== 32'h0001_0000) begin errors++; $display("FAIL simul_no_ovf: got %h want 00010000", d); end
    endtask

    task automatic test_fill();
        logic [31:0] d;
        int bad = 0;
        burst(512, 32'h100);
        idle(4);
        wb_read(4'd0, d);
        checks++;
        if (d !== 32'h0002_0200) begin errors++; $display("FAIL fill_full: got %h want 00020200", d); end
        pulse(2'b01, 2'b00, 38'h3FF, 38'd0);
        idle(4);
        wb_read(4'd0, d);
        checks++;
        if (d !== 32'h0006_0200) begin errors++; $display("FAIL fill_ovf: got %h want 00060200", d); end
        wb_read(4'd5, d);
        checks++;
        if (d !== (DROPCNT ? 32'd1 : 32'd0)) begin errors++; $display("FAIL fill_drops: got %h want %h", d, DROPCNT ? 32'd1 : 32'd0); end
        for (int i = 0; i < 512; i++) begin
            wb_read(4'd3, d);
            checks++;
            if (d !== 32'(32'h100 + i)) begin
                errors++;
                if (bad < 8) $display("FAIL drain_lo_%0d: got %h want %h", i, d, 32'h100 + i);
                bad++;
            end
            wb_read(4'd4, d);
            checks++;
            if (d !== 32'h8000_0000) begin
                errors++;
                if (bad < 8) $display("FAIL drain_hi_%0d: got %h want 80000000", i, d);
                bad++;
            end
        end
        wb_read(4'd0, d);
        checks++;
        if (d !== 32'h0005_0000) begin errors++; $display("FAIL drain_empty: got %h want 00050000", d); end
        wb_write(4'd1, 32'h5);
        wb_read(4'd0, d);
        checks++;
        if (d !== 32'h0001_0000) begin errors++; $display("FAIL fill_clear: got %h want 00010000", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        wb_write(4'd2, 32'd3);
        wb_write(4'd1, 32'h3);
        pulse(2'b01, 2'b00, 38'd100, 38'd0);
        idle(4);
        pulse(2'b01, 2'b00, 38'd101, 38'd0);
        idle(4);
        checks++;
        if (wb_irq !== 1'b0) begin errors++; $display("FAIL irq_two: got %b want 0", wb_irq); end
        pulse(2'b01, 2'b00, 38'd102, 38'd0);
        @(negedge clk);
        checks++;
        if (wb_irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b want 0", wb_irq); end
        @(negedge clk);
        checks++;
        if (wb_irq !== 1'b1) begin errors++; $display("FAIL irq_three: got %b want 1", wb_irq); end
        wb_read(4'd4, d);
        @(negedge clk);
        checks++;
        if (wb_irq !== 1'b0) begin errors++; $display("FAIL irq_pop: got %b want 0", wb_irq); end
    endtask

    task automatic test_clear();
        logic [31:0] d;
        burst(10, 200);
        idle(4);
        wb_read(4'd0, d);
        checks++;
        if (d !== 32'h0000_000C) begin errors++; $display("FAIL clear_queued: got %h want 0000000c", d); end
        wb_write(4'd1, 32'h7);
        wb_read(4'd0, d);
        checks++;
        if (d !== 32'h0001_0000) begin errors++; $display("FAIL clear_status: got %h want 00010000", d); end
        wb_read(4'd1, d);
        checks++;
        if (d !== 32'h0000_0003) begin errors++; $display("FAIL clear_ctrl: got %h want 00000003", d); end
        wb_write(4'd1, 32'h1);
        wb_write(4'd2, 32'd1);
    endtask

    task automatic test_hold_drop();
        logic [31:0] d;
        logic [31:0] exp [4] = '{32'd10, 32'h8000_0000, 32'd11, 32'h8100_0000};
        logic [3:0]  adr [4] = '{4'd3, 4'd4, 4'd3, 4'd4};
        detect   = 2'b11;
        polarity = 2'b00;
        ts       = {38'd11, 38'd10};
        @(negedge clk);
        detect = 2'b10;
        ts     = {38'd12, 38'd10};
        @(negedge clk);
        detect = 2'b00;
        idle(4);
        wb_read(4'd0, d);
        checks++;
        if (d !== 32'h0004_0002) begin errors++; $display("FAIL hold_status: got %h want 00040002", d); end
        for (int i = 0; i < 4; i++) begin
            wb_read(adr[i], d);
            checks++;
            if (d !== exp[i]) begin errors++; $display("FAIL hold_entry_%0d: got %h want %h", i, d, exp[i]); end
        end
        wb_read(4'd5, d);
        checks++;
        if (d !== (DROPCNT ? 32'd1 : 32'd0)) begin errors++; $display("FAIL hold_drops: got %h want %h", d, DROPCNT ? 32'd1 : 32'd0); end
        wb_write(4'd1, 32'h5);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        burst(512, 32'h1000);
        idle(4);
        wb_read(4'd0, d);
        checks++;
        if (d !== 32'h0002_0200) begin errors++; $display("FAIL b2b_full: got %h want 00020200", d); end
        burst(2, 32'h2000);
        idle(4);
        wb_read(4'd0, d);
        checks++;
        if (d !== 32'h0006_0200) begin errors++; $display("FAIL b2b_ovf: got %h want 00060200", d); end
        wb_read(4'd5, d);
        checks++;
        if (d !== (DROPCNT ? 32'd2 : 32'd0)) begin errors++; $display("FAIL b2b_drops: got %h want %h", d, DROPCNT ? 32'd2 : 32'd0); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wb_write(4'd2, 32'd7);
        wb_write(4'd1, 32'h3);
        for (int i = 0; i < 6; i++) begin
            detect = 2'b11;
            ts     = {38'(i + 50), 38'(i + 40)};
            rst_n  = (i == 3) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        detect = 2'b00;
        rst_n  = 1'b1;
        idle(4);
        checks++;
        if (wb_irq !== 1'b0) begin errors++; $display("FAIL rstmid_irq: got %b want 0", wb_irq); end
        wb_read(4'd0, d);
        checks++;
        if (d !== 32'h0001_0000) begin errors++; $display("FAIL rstmid_status: got %h want 00010000", d); end
        wb_read(4'd1, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL rstmid_ctrl: got %h want 0", d); end
        wb_read(4'd2, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL rstmid_thresh: got %h want 1", d); end
        wb_read(4'd4, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL rstmid_data_hi: got %h want 0", d); end
        wb_read(4'd5, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL rstmid_drops: got %h want 0", d); end
    endtask

    initial begin
        rst_n    = 1'b0;
        detect   = 2'b00;
        polarity = 2'b00;
        ts       = '0;
        wb_addr  = '0;
        wb_wdat  = '0;
        wb_cyc   = 1'b0;
        wb_stb   = 1'b0;
        wb_we    = 1'b0;
        wb_sel   = 4'hF;
        @(negedge clk);
        test_reset();
        test_single();
        test_simultaneous();
        test_fill();
        test_irq();
        test_clear();
        test_hold_drop();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
